// File: rtl/uart_print_arbiter.sv
// Line-atomic arbiter: NUM_REQ character FIFOs share one UART write port.
// A source is granted only once it holds a full line (or is full), then drained to '\n'.
module uart_print_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter int         FIFO_DEPTH = 16,
  parameter int         GAP_CYCLES = 0,
  parameter logic [9:0] UART_ADDR  = 10'h000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_en,
  output logic                       uart_wr_en,
  output logic [9:0]                 uart_addr,
  output logic [31:0]                uart_wr_data,
  output logic [3:0]                 uart_wr_byte_en,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] NL = 8'h0A;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state;
  logic [7:0]     mem    [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr [NUM_REQ];
  logic [PW-1:0]  rd_ptr [NUM_REQ];
  logic [CW-1:0]  count  [NUM_REQ];
  logic [CW-1:0]  nl_cnt [NUM_REQ];
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  pick;
  logic [GW-1:0]  gap_cnt;
  logic           released_q;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] eligible;
  logic           any_elig;
  logic           release_now;
  logic [7:0]     head;
  int             rr_idx;

  always_comb begin
    req_ready = '0;
    push      = '0;
    pop       = '0;
    eligible  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (count[i] < CW'(FIFO_DEPTH));
      push[i]      = req_valid[i] && req_ready[i];
      pop[i]       = (state == SEND) && (grant_id == IW'(i));
      eligible[i]  = (nl_cnt[i] != '0) || (count[i] == CW'(FIFO_DEPTH));
    end
  end

  assign head        = mem[grant_id][rd_ptr[grant_id]];
  // Same-cycle push keeps the FIFO non-empty, so the grant is held.
  assign release_now = (head == NL) || ((count[grant_id] == CW'(1)) && !push[grant_id]);

  // Round-robin: scan from the highest offset down so the nearest eligible source wins.
  always_comb begin
    any_elig = 1'b0;
    pick     = rr_ptr;
    rr_idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (eligible[rr_idx]) begin
        any_elig = 1'b1;
        pick     = IW'(rr_idx);
      end
    end
  end

  assign uart_en         = (state == SEND);
  assign uart_wr_en      = uart_en;
  assign uart_addr       = UART_ADDR;
  assign uart_wr_data    = uart_en ? {24'h0, head} : 32'h0;
  assign uart_wr_byte_en = uart_en ? 4'b0001 : 4'b0000;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        nl_cnt[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]  <= count[i] + CW'(push[i]) - CW'(pop[i]);
        nl_cnt[i] <= nl_cnt[i] + CW'(push[i] && (req_data[8*i +: 8] == NL))
                               - CW'(pop[i] && (head == NL));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      gap_cnt    <= '0;
      released_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            grant_id <= pick;
            state    <= SEND;
          end
        end
        SEND: begin
          if (release_now) begin
            rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
          if (GAP_CYCLES > 0) begin
            state      <= GAP;
            gap_cnt    <= GW'(GAP_CYCLES - 1);
            released_q <= release_now;
          end else if (release_now) begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= released_q ? IDLE : SEND;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_print_arbiter.sv
// Bench for uart_print_arbiter: directed scenarios plus random lines checked
// against per-source character queues and a line-atomicity rule.
module tb_uart_print_arbiter;
  localparam int NR = 4;
  localparam logic [7:0] NL = 8'h0A;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_en, uart_wr_en, busy;
  logic [9:0]  uart_addr;
  logic [31:0] uart_wr_data;
  logic [3:0]  uart_wr_byte_en;
  logic [1:0]  grant_id;

  logic [3:0]  g_valid;
  logic [31:0] g_data;
  logic [3:0]  g_ready;
  logic        g_uart_en, g_uart_wr_en, g_busy;
  logic [9:0]  g_uart_addr;
  logic [31:0] g_uart_wr_data;
  logic [3:0]  g_uart_wr_byte_en;
  logic [1:0]  g_grant_id;

  always #5 clk = ~clk;

  uart_print_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(16), .GAP_CYCLES(0), .UART_ADDR(10'h000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .uart_en(uart_en), .uart_wr_en(uart_wr_en), .uart_addr(uart_addr),
    .uart_wr_data(uart_wr_data), .uart_wr_byte_en(uart_wr_byte_en),
    .busy(busy), .grant_id(grant_id));

  uart_print_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(16), .GAP_CYCLES(3), .UART_ADDR(10'h000)) dut_gap (
    .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data), .req_ready(g_ready),
    .uart_en(g_uart_en), .uart_wr_en(g_uart_wr_en), .uart_addr(g_uart_addr),
    .uart_wr_data(g_uart_wr_data), .uart_wr_byte_en(g_uart_wr_byte_en),
    .busy(g_busy), .grant_id(g_grant_id));

  int vectors = 0;
  int errors  = 0;
  int pushed_total = 0;
  int sent_total   = 0;

  // Reference: each source's accepted-but-unsent characters, in order.
  logic [7:0] mdl [NR][$];
  logic [7:0] log_c [$];
  int         log_g [$];
  logic       owner_open = 1'b0;
  int         owner = 0;
  int         mon_g;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_en) begin
        mon_g = int'(grant_id);
        vectors++;
        if (uart_wr_en !== 1'b1 || uart_wr_byte_en !== 4'b0001 || uart_addr !== 10'h000 ||
            uart_wr_data[31:8] !== 24'h0) begin
          errors++;
          $display("FAIL mon_ctrl: wr_en=%b byte_en=%b addr=%h data=%h, required 1/0001/000/{24'h0,char}",
                   uart_wr_en, uart_wr_byte_en, uart_addr, uart_wr_data);
        end
        vectors++;
        if (mdl[mon_g].size() == 0) begin
          errors++;
          $display("FAIL mon_data: source %0d wrote %h, required no write (queue empty)",
                   mon_g, uart_wr_data[7:0]);
        end else begin
          mon_exp = mdl[mon_g].pop_front();
          if (uart_wr_data[7:0] !== mon_exp) begin
            errors++;
            $display("FAIL mon_data: source %0d got %h, required %h", mon_g, uart_wr_data[7:0], mon_exp);
          end
        end
        vectors++;
        if (owner_open && owner != mon_g) begin
          errors++;
          $display("FAIL mon_interleave: grant %0d, required %0d (line still open)", mon_g, owner);
        end
        sent_total++;
        log_c.push_back(uart_wr_data[7:0]);
        log_g.push_back(mon_g);
        if (uart_wr_data[7:0] == NL || mdl[mon_g].size() == 0) owner_open = 1'b0;
        else begin
          owner_open = 1'b1;
          owner = mon_g;
        end
      end else begin
        vectors++;
        if (uart_wr_en !== 1'b0 || uart_wr_byte_en !== 4'b0000) begin
          errors++;
          $display("FAIL mon_idle: wr_en=%b byte_en=%b, required 0/0000", uart_wr_en, uart_wr_byte_en);
        end
      end
    end
  end

  task automatic flush_model();
    for (int r = 0; r < NR; r++) mdl[r].delete();
    owner_open = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    g_valid = '0;
    flush_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_char(input int r, input logic [7:0] c);
    int guard = 0;
    while (!req_ready[r] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL push_timeout: source %0d ready=%b after %0d cycles, required 1", r, req_ready[r], guard);
    end
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = c;
    mdl[r].push_back(c);
    pushed_total++;
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int guard = 0;
    while ((log_c.size() < n || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL %s_timeout: %0d writes seen, required %0d", name, log_c.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 7;
    if (uart_en !== 1'b0)          begin errors++; $display("FAIL rst_uart_en: %b, required 0", uart_en); end
    if (uart_wr_en !== 1'b0)       begin errors++; $display("FAIL rst_wr_en: %b, required 0", uart_wr_en); end
    if (uart_wr_byte_en !== 4'h0)  begin errors++; $display("FAIL rst_byte_en: %b, required 0000", uart_wr_byte_en); end
    if (uart_wr_data !== 32'h0)    begin errors++; $display("FAIL rst_wr_data: %h, required 0", uart_wr_data); end
    if (busy !== 1'b0)             begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    if (req_ready !== 4'hF)        begin errors++; $display("FAIL rst_ready: %b, required 1111", req_ready); end
    if (grant_id !== 2'd0)         begin errors++; $display("FAIL rst_grant: %0d, required 0", grant_id); end
  endtask

  task automatic test_hi_line();
    logic [7:0] exp [3];
    exp[0] = 8'h48; exp[1] = 8'h69; exp[2] = NL;
    push_char(0, 8'h48);
    push_char(0, 8'h69);
    push_char(0, NL);
    // The cycle right after the '\n' edge is the arbitration cycle.
    vectors++;
    if (uart_en !== 1'b0) begin errors++; $display("FAIL hi_arb: uart_en=%b, required 0", uart_en); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (uart_en !== 1'b1 || uart_wr_data !== {24'h0, exp[k]}) begin
        errors++;
        $display("FAIL hi_char%0d: en=%b data=%h, required 1 %h", k, uart_en, uart_wr_data, exp[k]);
      end
    end
    @(negedge clk);
    vectors++;
    if (uart_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hi_end: en=%b busy=%b, required 0 0", uart_en, busy);
    end
  endtask

  task automatic test_line_hold();
    log_c.delete(); log_g.delete();
    push_char(0, 8'h41);
    push_char(0, 8'h42);
    push_char(1, 8'h43);
    push_char(1, NL);
    wait_log(2, "hold1");
    vectors++;
    if (log_c.size() != 2 || log_c[0] !== 8'h43 || log_c[1] !== NL || log_g[0] != 1 || log_g[1] != 1) begin
      errors++;
      $display("FAIL hold_first: %0d writes, first %h, required 2 writes 43 0A from source 1",
               log_c.size(), log_c.size() > 0 ? log_c[0] : 8'h00);
    end
    vectors++;
    if (grant_id !== 2'd1) begin errors++; $display("FAIL hold_grant1: %0d, required 1", grant_id); end
    push_char(0, NL);
    wait_log(5, "hold2");
    vectors++;
    if (log_c.size() != 5 || log_c[2] !== 8'h41 || log_c[3] !== 8'h42 || log_c[4] !== NL ||
        log_g[2] != 0 || log_g[4] != 0) begin
      errors++;
      $display("FAIL hold_second: %0d writes, required 5 ending 41 42 0A from source 0", log_c.size());
    end
    vectors++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL hold_grant0: %0d, required 0", grant_id); end
  endtask

  task automatic push_multi(input logic [3:0] mask);
    req_valid = mask;
    req_data  = {4{8'h78}};
    for (int r = 0; r < NR; r++) if (mask[r]) begin mdl[r].push_back(8'h78); pushed_total++; end
    @(negedge clk);
    req_data = {4{NL}};
    for (int r = 0; r < NR; r++) if (mask[r]) begin mdl[r].push_back(NL); pushed_total++; end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp2 [2];
    exp2[0] = 0; exp2[1] = 3;
    do_reset();
    log_c.delete(); log_g.delete();
    push_multi(4'b1111);
    wait_log(8, "rr1");
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (log_g.size() < 8 || log_g[2*k] != k || log_g[2*k+1] != k) begin
        errors++;
        $display("FAIL rr_line%0d: source %0d, required %0d", k, log_g.size() > 2*k ? log_g[2*k] : -1, k);
      end
    end
    push_multi(4'b1001);
    wait_log(12, "rr2");
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (log_g.size() < 12 || log_g[8+2*k] != exp2[k] || log_g[9+2*k] != exp2[k]) begin
        errors++;
        $display("FAIL rr_wrap%0d: source %0d, required %0d", k, log_g.size() > 8+2*k ? log_g[8+2*k] : -1, exp2[k]);
      end
    end
  endtask

  task automatic test_full_drain();
    int guard = 0;
    int n = 0;
    for (int k = 0; k < 16; k++) push_char(2, 8'h61 + 8'(k));
    vectors++;
    if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL full_ready: %b, required 0", req_ready[2]); end
    while (!uart_en && guard < 20) begin @(negedge clk); guard++; end
    while (uart_en && n < 40) begin n++; @(negedge clk); end
    vectors++;
    if (n != 16) begin errors++; $display("FAIL full_burst: %0d consecutive writes, required 16", n); end
    vectors++;
    if (busy !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL full_release: busy=%b ready=%b, required 0 1", busy, req_ready[2]);
    end
  endtask

  task automatic test_gap();
    int cyc [$];
    logic [7:0] dat [$];
    logic busy_ok = 1'b1;
    logic [7:0] s [3];
    s[0] = 8'h61; s[1] = 8'h62; s[2] = NL;
    for (int k = 0; k < 3; k++) begin
      g_valid[1] = 1'b1;
      g_data[15:8] = s[k];
      @(negedge clk);
    end
    g_valid = '0;
    for (int t = 0; t < 40; t++) begin
      if (g_uart_en) begin
        cyc.push_back(t);
        dat.push_back(g_uart_wr_data[7:0]);
      end else if (cyc.size() > 0 && cyc.size() < 3 && !g_busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (cyc.size() != 3) begin
      errors++;
      $display("FAIL gap_pulses: %0d, required 3", cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dat[k] !== s[k]) begin errors++; $display("FAIL gap_data%0d: %h, required %h", k, dat[k], s[k]); end
      end
      vectors += 2;
      if (cyc[1] - cyc[0] != 4) begin errors++; $display("FAIL gap_space0: %0d, required 4", cyc[1] - cyc[0]); end
      if (cyc[2] - cyc[1] != 4) begin errors++; $display("FAIL gap_space1: %0d, required 4", cyc[2] - cyc[1]); end
    end
    vectors++;
    if (!busy_ok) begin errors++; $display("FAIL gap_busy: busy dropped between pulses, required 1"); end
  endtask

  task automatic test_random();
    int len, r, guard, pb, sb, left;
    pb = pushed_total;
    sb = sent_total;
    for (int l = 0; l < 30; l++) begin
      r   = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) push_char(r, 8'h61 + 8'($urandom_range(0, 25)));
      push_char(r, NL);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    guard = 0;
    left = 1;
    while ((left != 0 || busy) && guard < 4000) begin
      @(negedge clk);
      guard++;
      left = 0;
      for (int q = 0; q < NR; q++) left += mdl[q].size();
    end
    vectors++;
    if (left != 0 || (sent_total - sb) != (pushed_total - pb)) begin
      errors++;
      $display("FAIL rand_drain: sent %0d, %0d still queued, required %0d sent, 0 queued",
               sent_total - sb, left, pushed_total - pb);
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] s [6];
    int n = 0;
    int guard = 0;
    int stray = 0;
    s[0] = 8'h68; s[1] = 8'h65; s[2] = 8'h6C; s[3] = 8'h6C; s[4] = 8'h6F; s[5] = NL;
    for (int k = 0; k < 6; k++) push_char(0, s[k]);
    while (n < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (uart_en) n++;
    end
    vectors++;
    if (n != 2) begin errors++; $display("FAIL mid_start: %0d writes, required 2", n); end
    rst = 1'b1;
    flush_model();
    @(negedge clk);
    vectors += 3;
    if (uart_en !== 1'b0)   begin errors++; $display("FAIL mid_en: %b, required 0", uart_en); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: %b, required 0", busy); end
    if (req_ready !== 4'hF) begin errors++; $display("FAIL mid_ready: %b, required 1111", req_ready); end
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (uart_en) stray++;
    end
    vectors++;
    if (stray != 0) begin errors++; $display("FAIL mid_stray: %0d writes, required 0", stray); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    g_valid   = '0;
    g_data    = '0;
    @(negedge clk);
    test_reset();
    test_hi_line();
    test_line_hold();
    test_round_robin();
    test_full_drain();
    test_gap();
    test_random();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
